// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Qualifies the PLL lock flag and releases the core reset, then the CPU
//   reset, in stages. Generates the CPU clock enable while running and
//   records any loss of lock that occurs after the core has been released.
//
// Ports:
//   clk_sys        in   PLL-derived system clock
//   rst_n          in   synchronous active-low reset
//   pll_locked     in   PLL lock flag (asynchronous to clk_sys)
//   soft_reset     in   user/OSD reset request (synchronous to clk_sys)
//   rst_core_n     out  core reset, active-low
//   rst_cpu_n      out  CPU reset, active-low
//   ready          out  high only in RUN
//   ce_cpu         out  one-cycle CPU clock-enable pulse, every CE_DIV cycles in RUN
//   lock_lost      out  sticky lock-loss flag
//   lock_loss_cnt  out  saturating count of lock losses
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned SOFT_MIN    = 64,
  parameter int unsigned CE_DIV      = 5
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       rst_core_n,
  output logic       rst_cpu_n,
  output logic       ready,
  output logic       ce_cpu,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MAX_AB  = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int unsigned CNT_MAX = (MAX_AB > SOFT_MIN) ? MAX_AB : SOFT_MIN;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_MIN - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CE_DIV - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    COUNT,
    REL_CORE,
    RUN,
    SOFT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic          sync_q1;
  logic          locked_s;
  logic          soft_q;
  logic          lock_drop;
  logic          soft_go;

  // Two-flop synchronizer for the lock flag; soft_reset is registered once
  // so the FSM acts one edge after the request is sampled.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
      soft_q   <= 1'b0;
    end else begin
      sync_q1  <= pll_locked;
      locked_s <= sync_q1;
      soft_q   <= soft_reset;
    end
  end

  // Lock loss outranks soft reset, which outranks the normal state flow.
  always_comb begin
    lock_drop = 1'b0;
    soft_go   = 1'b0;
    if (!locked_s && (state == REL_CORE || state == RUN || state == SOFT))
      lock_drop = 1'b1;
    if (soft_q && (state == REL_CORE || state == RUN))
      soft_go = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      div           <= '0;
      rst_core_n    <= 1'b0;
      rst_cpu_n     <= 1'b0;
      ready         <= 1'b0;
      ce_cpu        <= 1'b0;
      lock_lost     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      // Divider and enable stay cleared unless RUN continues below.
      ce_cpu <= 1'b0;
      div    <= '0;
      if (lock_drop) begin
        state      <= WAIT_LOCK;
        cnt        <= '0;
        rst_core_n <= 1'b0;
        rst_cpu_n  <= 1'b0;
        ready      <= 1'b0;
        lock_lost  <= 1'b1;
        if (lock_loss_cnt != 8'hFF)
          lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end else if (soft_go) begin
        state      <= SOFT;
        cnt        <= '0;
        rst_core_n <= 1'b0;
        rst_cpu_n  <= 1'b0;
        ready      <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            rst_core_n <= 1'b0;
            rst_cpu_n  <= 1'b0;
            ready      <= 1'b0;
            cnt        <= '0;
            if (locked_s)
              state <= COUNT;
          end
          COUNT: begin
            if (!locked_s) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == LOCK_LAST) begin
              state      <= REL_CORE;
              cnt        <= '0;
              rst_core_n <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REL_CORE: begin
            if (cnt == GAP_LAST) begin
              state     <= RUN;
              cnt       <= '0;
              rst_cpu_n <= 1'b1;
              ready     <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            ce_cpu <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
          end
          SOFT: begin
            if (cnt == SOFT_LAST) begin
              if (!soft_q) begin
                state      <= REL_CORE;
                cnt        <= '0;
                rst_core_n <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            rst_core_n <= 1'b0;
            rst_cpu_n  <= 1'b0;
            ready      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with LOCK_STABLE=16, STAGE_GAP=4,
//   SOFT_MIN=8, CE_DIV=5. Edge numbers in comments count from the edge that
//   first samples the stimulus change being exercised.
module tb_pll_reset_sequencer;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset;
  logic       rst_core_n;
  logic       rst_cpu_n;
  logic       ready;
  logic       ce_cpu;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int e     = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE (16),
    .STAGE_GAP   (4),
    .SOFT_MIN    (8),
    .CE_DIV      (5)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .soft_reset    (soft_reset),
    .rst_core_n    (rst_core_n),
    .rst_cpu_n     (rst_cpu_n),
    .ready         (ready),
    .ce_cpu        (ce_cpu),
    .lock_lost     (lock_lost),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Advance one edge; outputs are then observed 1 ns after it.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    e++;
  endtask

  task automatic step_to(input int t);
    while (e < t) tick();
  endtask

  task automatic check_all_low(input string tag);
    check({tag, " outs"}, {27'd0, rst_core_n, rst_cpu_n, ready, ce_cpu, lock_lost}, 32'd0);
    check({tag, " cnt"}, {24'd0, lock_loss_cnt}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    repeat (3) tick();
    check_all_low("reset");
    rst_n = 1'b1;
    repeat (4) tick();
    check("wait_lock core", {31'd0, rst_core_n}, 32'd0);

    // Power-up with a one-cycle glitch while COUNT holds cnt=10.
    pll_locked = 1'b1;
    e = -1;
    tick();                     // edge 0
    step_to(10);
    pll_locked = 1'b0;
    tick();                     // edge 11 samples low
    pll_locked = 1'b1;
    tick();                     // edge 12 samples high: new edge 0
    step_to(18);
    check("glitch delays core", {31'd0, rst_core_n}, 32'd0);
    step_to(29);
    check("core before rel", {31'd0, rst_core_n}, 32'd0);
    tick();                     // 12+18
    check("core released", {31'd0, rst_core_n}, 32'd1);
    check("cpu held", {31'd0, rst_cpu_n}, 32'd0);
    step_to(33);
    check("cpu before rel", {31'd0, rst_cpu_n}, 32'd0);
    tick();                     // 12+22: RUN entry
    check("cpu released", {31'd0, rst_cpu_n}, 32'd1);
    check("ready", {31'd0, ready}, 32'd1);
    check("ce at entry", {31'd0, ce_cpu}, 32'd0);
    for (int j = 1; j <= 11; j++) begin
      tick();
      check($sformatf("ce run+%0d", j), {31'd0, ce_cpu}, {31'd0, (j % 5) == 0});
    end
    check("no lock_lost", {31'd0, lock_lost}, 32'd0);
    check("no loss cnt", {24'd0, lock_loss_cnt}, 32'd0);

    // Loss in RUN: sampled at edge k, resets low after k+2.
    pll_locked = 1'b0;
    e = -1;
    tick();                     // k = 0
    tick();
    check("loss k+1 ready", {31'd0, ready}, 32'd1);
    tick();
    check("loss outs", {28'd0, rst_core_n, rst_cpu_n, ready, ce_cpu}, 32'd0);
    check("loss flag", {31'd0, lock_lost}, 32'd1);
    check("loss cnt 1", {24'd0, lock_loss_cnt}, 32'd1);
    repeat (6) tick();
    check("ce stopped", {31'd0, ce_cpu}, 32'd0);

    // Re-lock repeats the full sequence; flag stays set.
    pll_locked = 1'b1;
    e = -1;
    tick();
    step_to(17);
    check("relock core held", {31'd0, rst_core_n}, 32'd0);
    tick();
    check("relock core", {31'd0, rst_core_n}, 32'd1);
    step_to(22);
    check("relock ready", {31'd0, ready}, 32'd1);
    check("relock flag", {31'd0, lock_lost}, 32'd1);

    // Two-cycle soft reset: sampled at a, resets low after a+1 for 8 cycles.
    repeat (3) tick();
    soft_reset = 1'b1;
    e = -1;
    tick();                     // a = 0
    check("soft a cpu", {31'd0, rst_cpu_n}, 32'd1);
    tick();
    soft_reset = 1'b0;
    check("soft a+1 outs", {29'd0, rst_core_n, rst_cpu_n, ready}, 32'd0);
    step_to(8);
    check("soft hold core", {31'd0, rst_core_n}, 32'd0);
    tick();
    check("soft core rel", {31'd0, rst_core_n}, 32'd1);
    step_to(12);
    check("soft cpu held", {31'd0, rst_cpu_n}, 32'd0);
    tick();
    check("soft cpu rel", {31'd0, rst_cpu_n}, 32'd1);

    // Twenty-cycle soft reset: hold extends until soft_q clears.
    repeat (2) tick();
    soft_reset = 1'b1;
    e = -1;
    tick();                     // a = 0
    step_to(19);
    soft_reset = 1'b0;
    step_to(20);
    check("long soft core", {31'd0, rst_core_n}, 32'd0);
    check("long soft ce", {31'd0, ce_cpu}, 32'd0);
    tick();
    check("long soft rel", {31'd0, rst_core_n}, 32'd1);
    step_to(24);
    check("long cpu held", {31'd0, rst_cpu_n}, 32'd0);
    tick();
    check("long cpu rel", {31'd0, rst_cpu_n}, 32'd1);

    // Lock loss and soft reset reach the FSM on the same edge.
    repeat (2) tick();
    pll_locked = 1'b0;
    tick();                     // k
    soft_reset = 1'b1;
    tick();                     // k+1 samples soft
    soft_reset = 1'b0;
    tick();                     // k+2
    check("both loss wins", {24'd0, lock_loss_cnt}, 32'd2);
    check("both outs", {29'd0, rst_core_n, rst_cpu_n, ready}, 32'd0);
    repeat (2) tick();

    // Saturation: each iteration reaches REL_CORE then loses lock.
    pll_locked = 1'b1;
    repeat (19) tick();
    check("sat start core", {31'd0, rst_core_n}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      if (i == 0)   check("sat i0", {24'd0, lock_loss_cnt}, 32'd3);
      if (i == 251) check("sat 254", {24'd0, lock_loss_cnt}, 32'd254);
      if (i == 252) check("sat 255", {24'd0, lock_loss_cnt}, 32'd255);
      pll_locked = 1'b1;
      repeat (19) tick();
    end
    check("sat hold", {24'd0, lock_loss_cnt}, 32'd255);
    check("sat flag", {31'd0, lock_lost}, 32'd1);

    // Synchronous reset in RUN with lock_lost set.
    repeat (4) tick();
    check("pre rst ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b0;
    e = -1;
    tick();                     // r = 0
    rst_n = 1'b1;
    check_all_low("midrun rst");
    step_to(18);
    check("post rst core held", {31'd0, rst_core_n}, 32'd0);
    tick();
    check("post rst core", {31'd0, rst_core_n}, 32'd1);
    check("post rst flag", {31'd0, lock_lost}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sits directly downstream of the system PLL. Consumes the PLL `locked` flag, qualifies it, and sequences staged synchronous reset release to the core and CPU. Generates the CPU clock enable (default 10 MHz / 5 = 2 MHz) and records any loss of lock.

## Interface
Parameters:
- `LOCK_STABLE`, default 1024: number of consecutive cycles `locked` must stay high before core reset release. Legal range is ≥2.
- `STAGE_GAP`, default 16: number of cycles between core reset release and CPU reset release. Legal range is ≥1.
- `SOFT_MIN`, default 64: minimum length of a soft reset, in cycles. Legal range is ≥1.
- `CE_DIV`, default 5: CPU clock-enable divide ratio. Legal range is ≥2.

Ports:
- `clk_sys` in 1: the single clock, taken from the PLL 10 MHz output.
- `rst_n` in 1: reset, synchronous and active-low.
- `pll_locked` in 1: PLL lock flag. It is asynchronous to `clk_sys`.
- `soft_reset` in 1: OSD/user reset request, synchronous to `clk_sys`.
- `rst_core_n` out 1: core reset, active-low.
- `rst_cpu_n` out 1: CPU reset, active-low.
- `ready` out 1: high only in the RUN state.
- `ce_cpu` out 1: one-cycle CPU clock-enable pulse.
- `lock_lost` out 1: sticky flag, set when lock is lost after core release.
- `lock_loss_cnt` out 8: count of lock losses after core release. It saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. All outputs are registered.
- `rst_n`=0 forces the following on the next edge:
  - state goes to WAIT_LOCK;
  - all counters are set to 0;
  - the synchronizer is cleared;
  - `rst_core_n`=0, `rst_cpu_n`=0, `ready`=0, `ce_cpu`=0, `lock_lost`=0, `lock_loss_cnt`=0.
- States and transitions. The cycle counter `cnt` is cleared on every state entry.
  - WAIT_LOCK: both resets are asserted. When `locked_s`=1, go to COUNT.
  - COUNT: `cnt` increments each cycle. If `locked_s`=0, go to WAIT_LOCK with no flag set. When `cnt`=LOCK_STABLE-1, go to REL_CORE and set `rst_core_n`=1.
  - REL_CORE: `cnt` increments each cycle. When `cnt`=STAGE_GAP-1, go to RUN and set `rst_cpu_n`=1 and `ready`=1.
  - RUN: steady operating state.
  - SOFT: both resets are asserted and `ready`=0. `cnt` increments and saturates at SOFT_MIN-1. When `cnt`=SOFT_MIN-1 and `soft_reset`=0, go to REL_CORE and set `rst_core_n`=1. The lock-stability count is skipped.
- Lock loss:
  - If `locked_s`=0 in REL_CORE, RUN or SOFT, go to WAIT_LOCK. Both resets go to 0 and `ready`=0 on the same edge.
  - In the same cycle, `lock_lost` is set to 1 and `lock_loss_cnt` increments; the count holds at 255.
- Soft reset: `soft_reset`=1 in REL_CORE or RUN → SOFT. It is ignored in WAIT_LOCK, COUNT and SOFT entry, because resets are already held.
- Priority: lock loss beats soft reset, and soft reset beats the normal transition.
- `ce_cpu`:
  - The divider counter is held at 0 outside RUN.
  - In RUN it counts 0..CE_DIV-1 and wraps. `ce_cpu` is registered high for the cycle after the divider reaches CE_DIV-1.
  - `ce_cpu` is forced to 0 on the edge that leaves RUN.
- `lock_lost` and `lock_loss_cnt` are cleared only by `rst_n`.

## Timing
Edge 0 is the first edge that samples `pll_locked`=1.
- `locked_s` goes high after edge 1.
- The state becomes COUNT after edge 2.
- `rst_core_n` goes high after edge LOCK_STABLE+2.
- `rst_cpu_n` and `ready` go high after edge LOCK_STABLE+2+STAGE_GAP.
- The first `ce_cpu` pulse is high CE_DIV cycles after RUN entry. Subsequent pulses repeat exactly every CE_DIV cycles.
- Lock-loss latency: `pll_locked` falling sampled at edge k → resets low after edge k+2.
- Soft reset:
  - `soft_reset` sampled high at edge k → resets low after edge k+1.
  - Minimum hold is SOFT_MIN cycles in SOFT. The hold extends while `soft_reset` stays high.
  - Then STAGE_GAP cycles in REL_CORE before `rst_cpu_n` rises.
- Reset mid-operation: `rst_n` low at any edge → all outputs take their reset values after that edge, regardless of state.

## Test plan
- Power-up (LOCK_STABLE=16, STAGE_GAP=4, CE_DIV=5): `pll_locked` rises and is sampled at edge 0 → `rst_core_n` rises after edge 18; `rst_cpu_n` and `ready` rise after edge 22; `ce_cpu` pulses every 5th cycle thereafter. `lock_lost`=0.
- Glitch during COUNT: `pll_locked` low for 1 cycle when `cnt`=10 → state returns to WAIT_LOCK and the count restarts. Release is delayed by the full 16+ cycles. `lock_lost` stays 0 and `lock_loss_cnt` stays 0.
- Loss in RUN: `pll_locked` drops at edge k → resets and `ready` low after edge k+2, `ce_cpu` stops, `lock_lost`=1, `lock_loss_cnt`=1. Re-lock → the full sequence repeats and `lock_lost` stays 1.
- Saturation: 300 lock/loss cycles, each reaching REL_CORE → `lock_loss_cnt`=255 and holds.
- Soft reset (SOFT_MIN=8): a 2-cycle `soft_reset` pulse in RUN → resets low for exactly 8 cycles, then `rst_core_n` rises, then `rst_cpu_n` rises 4 cycles later. A 20-cycle pulse → resets are held until `soft_reset` falls. A simultaneous lock loss → WAIT_LOCK wins.
- Synchronous reset: `rst_n`=0 for one edge in RUN with `lock_lost`=1 → next cycle all outputs are 0 and the state is WAIT_LOCK. With `pll_locked` still high, re-release happens after LOCK_STABLE+2 edges.
